sipo_rx_controller: RTL and testbench

Framed serial receive controller built around the team's SIPO deserialiser.
- Detects a start bit and sequences DATA_WIDTH data-bit shifts, with an optional parity bit and a stop-bit check.
- Commits good words to a one-entry holding register and presents them downstream on a valid/ready handshake.
- Sits between the raw serial pin logic and the word-level consumer; reports parity, framing and overrun errors.

---
 rtl/sipo_rx_controller_if.sv | 8 +
 rtl/sipo_rx_controller.sv | 75 +++++++
 tb/tb_sipo_rx_controller.sv | 121 ++++++++++++
 3 files changed

// File: rtl/sipo_rx_controller_if.sv
// sipo_rx_controller_if: word-level valid/ready handshake between the receiver and its consumer
interface sipo_rx_controller_if #(parameter int DATA_WIDTH = 4);
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  modport master(output out_data, output out_valid, input out_ready);
  modport slave(input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/sipo_rx_controller.sv
// sipo_rx_controller: framed serial receiver with parity/stop check and a one-entry valid/ready holding register
module sipo_rx_controller #(
  parameter int DATA_WIDTH = 4,
  parameter int LSB_FIRST  = 1,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 serial_in,
  input  logic                 enable,
  sipo_rx_controller_if.master rx,
  output logic                 busy,
  output logic                 parity_error,
  output logic                 frame_error,
  output logic                 overrun
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [1:0] IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3;
  logic [1:0]            state;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] sr;
  logic                  par_bad;
  logic                  last_bit;
  logic                  good;
  assign last_bit = cnt == CW'(DATA_WIDTH - 1);
  assign good     = enable && serial_in && !par_bad;
  assign busy     = state != IDLE;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      sr           <= '0;
      par_bad      <= 1'b0;
      rx.out_data  <= '0;
      rx.out_valid <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
      overrun      <= 1'b0;
      if (rx.out_valid && rx.out_ready) rx.out_valid <= 1'b0;
      case (state)
        IDLE: if (enable && !serial_in) begin
          state   <= DATA;
          cnt     <= '0;
          par_bad <= 1'b0;
        end
        DATA: if (!enable) state <= IDLE;
        else begin
          sr    <= (LSB_FIRST != 0) ? {serial_in, sr[DATA_WIDTH-1:1]} : {sr[DATA_WIDTH-2:0], serial_in};
          cnt   <= cnt + CW'(1);
          state <= !last_bit ? DATA : (PARITY_EN != 0) ? PARITY : STOP;
        end
        PARITY: begin
          state   <= enable ? STOP : IDLE;
          par_bad <= ((^sr) ^ (PARITY_ODD != 0)) != serial_in;
        end
        default: begin
          state <= IDLE;
          frame_error  <= enable && !serial_in;
          parity_error <= enable && par_bad;
          // a commit into an occupied, undrained holding register is dropped as overrun
          if (good && (!rx.out_valid || rx.out_ready)) begin
            rx.out_data  <= sr;
            rx.out_valid <= 1'b1;
          end
          overrun <= good && rx.out_valid && !rx.out_ready;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sipo_rx_controller.sv
// tb_sipo_rx_controller: randomized and directed checks against a bit-queue frame model
module tb_sipo_rx_controller;
  localparam int W  = 4;
  localparam int LF = 1;
  localparam int PE = 1;
  localparam int PO = 0;
  logic clk = 0, reset = 0, serial_in = 1, enable = 0;
  logic busy, parity_error, frame_error, overrun;
  sipo_rx_controller_if #(.DATA_WIDTH(W)) rx();
  sipo_rx_controller #(.DATA_WIDTH(W), .LSB_FIRST(LF), .PARITY_EN(PE), .PARITY_ODD(PO)) dut (
    .clk(clk), .reset(reset), .serial_in(serial_in), .enable(enable), .rx(rx),
    .busy(busy), .parity_error(parity_error), .frame_error(frame_error), .overrun(overrun)
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  logic         m_valid;
  logic [W-1:0] m_data;
  bit           in_frame, e_pe, e_fe, e_ov;
  bit           q[$];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_valid = 0; m_data = '0; in_frame = 0; q.delete(); e_pe = 0; e_fe = 0; e_ov = 0;
  endtask
  task automatic compare();
    check("valid", {31'd0, rx.out_valid}, {31'd0, m_valid});
    check("data", 32'(rx.out_data), 32'(m_data));
    check("busy", {31'd0, busy}, {31'd0, in_frame});
    check("parity_error", {31'd0, parity_error}, {31'd0, e_pe});
    check("frame_error", {31'd0, frame_error}, {31'd0, e_fe});
    check("overrun", {31'd0, overrun}, {31'd0, e_ov});
  endtask
  // frame = start, W data bits, optional parity, stop; judged once the last bit arrives
  task automatic model_step(input bit ser, input bit en, input bit rdy);
    bit xfer, good;
    int ones;
    logic [W-1:0] word;
    xfer = m_valid && rdy; good = 0; ones = 0; word = '0;
    e_pe = 0; e_fe = 0; e_ov = 0;
    if (!in_frame) begin
      if (en && !ser) begin in_frame = 1; q.delete(); end
    end else if (!en) in_frame = 0;
    else begin
      q.push_back(ser);
      if (q.size() == W + PE + 1) begin
        for (int i = 0; i < W; i++) begin
          word[LF != 0 ? i : W - 1 - i] = q[i];
          ones += int'(q[i]);
        end
        if (PE != 0 && ((ones + int'(q[W])) % 2) != PO) e_pe = 1;
        e_fe = !q[q.size() - 1];
        good = !e_pe && !e_fe;
        in_frame = 0;
      end
    end
    if (good) begin
      if (!m_valid || rdy) begin m_data = word; m_valid = 1; end
      else e_ov = 1;
    end else if (xfer) m_valid = 0;
  endtask
  task automatic tick(input bit ser, input bit en, input bit rdy);
    serial_in = ser; enable = en; rx.out_ready = rdy;
    @(posedge clk);
    model_step(ser, en, rdy);
    #1 compare();
  endtask
  task automatic send(input logic [W-1:0] word, input bit bp, input bit bs, input bit rdy, input bit rdy_last);
    tick(0, 1, rdy);
    for (int i = 0; i < W; i++) tick(LF != 0 ? word[i] : word[W - 1 - i], 1, rdy);
    if (PE != 0) tick((^word) ^ (PO != 0) ^ bp, 1, rdy);
    tick(!bs, 1, rdy_last);
  endtask
  task automatic do_reset();
    reset = 0;
    #2;
    model_reset();
    compare();
    @(posedge clk);
    #1 reset = 1;
  endtask
  initial begin
    rx.out_ready = 0;
    #1 do_reset();
    send(4'b1011, 0, 0, 1, 1);
    check("t1_word", 32'(rx.out_data), 32'hB);
    tick(1, 1, 1);
    send(4'b1011, 1, 0, 1, 1);
    send(4'h5, 0, 1, 1, 1);
    send(4'h3, 0, 0, 0, 0);
    send(4'hA, 0, 0, 0, 0);
    check("t4_held", 32'(rx.out_data), 32'h3);
    tick(1, 1, 1);
    send(4'h6, 0, 0, 0, 0);
    send(4'h9, 0, 0, 0, 1);
    check("t5_new", 32'(rx.out_data), 32'h9);
    tick(1, 1, 1);
    tick(0, 1, 1); tick(1, 1, 1); tick(0, 1, 1); tick(1, 0, 1);
    check("t6_abort_busy", {31'd0, busy}, 32'd0);
    send(4'h7, 0, 0, 0, 0);
    tick(0, 1, 0); tick(1, 1, 0); tick(1, 1, 0);
    do_reset();
    send(4'hC, 0, 0, 1, 1);
    check("t6_after_reset", 32'(rx.out_data), 32'hC);
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0, 1: for (int k = 0; k < int'($urandom_range(1, 5)); k++)
                tick(1'($urandom), 1'($urandom_range(0, 4) != 0), 1'($urandom));
        2: if ($urandom_range(0, 3) == 0) do_reset(); else tick(1, 1, 1'($urandom));
        default: send(W'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
                      1'($urandom), 1'($urandom));
      endcase
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
